// File: rtl/mem_responder_pkg.sv
// Shared types for the memory responder: word type, FSM state encoding,
// latency counter type and the byte-address to word-index helper.
package mem_responder_pkg;

    typedef logic [31:0] rv32i_word;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } mem_rsp_state_t;

    localparam int unsigned RSP_CNT_W = 4;
    typedef logic [RSP_CNT_W-1:0] rsp_cnt_t;

    // Word index relative to the base address; 32-bit unsigned, so an
    // address below the base wraps to a huge index.
    function automatic rv32i_word word_index(input rv32i_word addr, input rv32i_word base);
        return (addr - base) >> 2;
    endfunction

endpackage

// File: rtl/mem_responder_be_sram.sv
// Word-wide storage array with per-byte-lane write enables and a registered
// read port. Contents are not reset.
module be_sram
    import mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned ADDR_W      = 10
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        we,
    input  rv32i_word         wdata,
    output rv32i_word         rdata
);

    rv32i_word mem_q [DEPTH_WORDS];
    rv32i_word rdata_q;

    // Byte-lane writes and read-before-write registered read of the same word
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata_q <= mem_q[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one word access at a time, commits it to the
// byte-enabled array after a programmable latency and returns a one-cycle
// resp pulse (with err on bad address or conflicting read+write).
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned LATENCY     = 2,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter rv32i_word   BASE_ADDR   = 32'h0000_0000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mem_read,
    input  logic       mem_write,
    input  rv32i_word  mem_address,
    input  rv32i_word  mem_wdata,
    input  logic [3:0] mem_mbe,
    output rv32i_word  mem_rdata,
    output logic       mem_resp,
    output logic       mem_err
);

    localparam int unsigned ADDR_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam rsp_cnt_t    CNT_INIT = rsp_cnt_t'(LATENCY - 1);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("mem_responder: LATENCY must be in 1..15");
    end
    if (DEPTH_WORDS == 0 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
        $error("mem_responder: DEPTH_WORDS must be a power of 2");
    end

    mem_rsp_state_t state_q, state_d;
    rsp_cnt_t       cnt_q, cnt_d;
    rv32i_word      addr_q, addr_d;
    rv32i_word      wdata_q, wdata_d;
    logic [3:0]     mbe_q, mbe_d;
    logic           rd_q, rd_d;
    logic           wr_q, wr_d;
    logic           resp_q, resp_d;
    logic           err_q, err_d;
    logic           rdata_sel_q, rdata_sel_d;

    // Access being committed this edge: live inputs on acceptance, latched otherwise
    rv32i_word      acc_addr;
    rv32i_word      acc_wdata;
    logic [3:0]     acc_mbe;
    logic           acc_rd;
    logic           acc_wr;
    logic           acc_err;
    logic           commit;
    rv32i_word      idx;
    logic [3:0]     sram_we;
    rv32i_word      sram_rdata;

    // Next-state, commit detection and array control
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mbe_d       = mbe_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        resp_d      = 1'b0;
        err_d       = 1'b0;
        rdata_sel_d = 1'b0;
        commit      = 1'b0;
        acc_addr    = addr_q;
        acc_wdata   = wdata_q;
        acc_mbe     = mbe_q;
        acc_rd      = rd_q;
        acc_wr      = wr_q;

        unique case (state_q)
            IDLE: begin
                if (mem_read || mem_write) begin
                    addr_d    = mem_address;
                    wdata_d   = mem_wdata;
                    mbe_d     = mem_mbe;
                    rd_d      = mem_read;
                    wr_d      = mem_write;
                    acc_addr  = mem_address;
                    acc_wdata = mem_wdata;
                    acc_mbe   = mem_mbe;
                    acc_rd    = mem_read;
                    acc_wr    = mem_write;
                    cnt_d     = CNT_INIT;
                    // LATENCY=1 commits on the acceptance edge itself
                    if (CNT_INIT == '0) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        idx     = word_index(acc_addr, BASE_ADDR);
        acc_err = (acc_addr < BASE_ADDR) || (idx >= DEPTH_WORDS) || (acc_rd && acc_wr);

        if (commit) begin
            resp_d      = 1'b1;
            err_d       = acc_err;
            rdata_sel_d = acc_rd && !acc_err;
        end

        // The array has no reset, so writes are also blocked while rst is held
        sram_we = (commit && acc_wr && !acc_err && rst) ? acc_mbe : '0;
    end

    // FSM and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            mbe_q       <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            resp_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_sel_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mbe_q       <= mbe_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            resp_q      <= resp_d;
            err_q       <= err_d;
            rdata_sel_q <= rdata_sel_d;
        end
    end

    be_sram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (ADDR_W)
    ) u_sram (
        .clk   (clk),
        .addr  (idx[ADDR_W-1:0]),
        .we    (sram_we),
        .wdata (acc_wdata),
        .rdata (sram_rdata)
    );

    assign mem_resp  = resp_q;
    assign mem_err   = err_q;
    assign mem_rdata = rdata_sel_q ? sram_rdata : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (LATENCY=2 default geometry, and
// LATENCY=1 with a small offset array), directed vector table, hand-written
// multi-cycle sequences and random traffic against a word-array model.
module tb_mem_responder;

    localparam int unsigned A_LAT   = 2;
    localparam int unsigned A_DEPTH = 1024;
    localparam logic [31:0] A_BASE  = 32'h0000_0000;
    localparam int unsigned B_LAT   = 1;
    localparam int unsigned B_DEPTH = 64;
    localparam logic [31:0] B_BASE  = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sel = 1'b0;
    logic        t_read = 1'b0;
    logic        t_write = 1'b0;
    logic [31:0] t_addr = '0;
    logic [31:0] t_wdata = '0;
    logic [3:0]  t_mbe = '0;

    logic        a_read, a_write, b_read, b_write;
    logic [31:0] a_rdata, b_rdata;
    logic        a_resp, b_resp, a_err, b_err;
    logic [31:0] o_rdata;
    logic        o_resp, o_err;

    int checks = 0;
    int errors = 0;

    logic [31:0] bmem [B_DEPTH];

    always #5 clk = ~clk;

    assign a_read  = !sel && t_read;
    assign a_write = !sel && t_write;
    assign b_read  = sel && t_read;
    assign b_write = sel && t_write;
    assign o_rdata = sel ? b_rdata : a_rdata;
    assign o_resp  = sel ? b_resp : a_resp;
    assign o_err   = sel ? b_err : a_err;

    mem_responder #(
        .LATENCY     (A_LAT),
        .DEPTH_WORDS (A_DEPTH),
        .BASE_ADDR   (A_BASE)
    ) dut_a (
        .clk         (clk),
        .rst         (rst),
        .mem_read    (a_read),
        .mem_write   (a_write),
        .mem_address (t_addr),
        .mem_wdata   (t_wdata),
        .mem_mbe     (t_mbe),
        .mem_rdata   (a_rdata),
        .mem_resp    (a_resp),
        .mem_err     (a_err)
    );

    mem_responder #(
        .LATENCY     (B_LAT),
        .DEPTH_WORDS (B_DEPTH),
        .BASE_ADDR   (B_BASE)
    ) dut_b (
        .clk         (clk),
        .rst         (rst),
        .mem_read    (b_read),
        .mem_write   (b_write),
        .mem_address (t_addr),
        .mem_wdata   (t_wdata),
        .mem_mbe     (t_mbe),
        .mem_rdata   (b_rdata),
        .mem_resp    (b_resp),
        .mem_err     (b_err)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mbe;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] mbe,
                                input logic [31:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.mbe = mbe;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one access and hold it until resp (or drop it after drop_after cycles).
    // lat counts rising edges from the acceptance edge (inclusive) to the resp sample.
    task automatic access(input logic s, input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] mbe, input int drop_after,
                          output logic [31:0] rdata, output logic err, output int lat);
        @(negedge clk);
        sel = s; t_read = rd; t_write = wr; t_addr = addr; t_wdata = wdata; t_mbe = mbe;
        lat = -1; rdata = '0; err = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (o_resp) begin
                lat = n; rdata = o_rdata; err = o_err;
                break;
            end
            if (n == drop_after) begin
                t_read = 1'b0; t_write = 1'b0;
            end
        end
        t_read = 1'b0; t_write = 1'b0;
        if (lat < 0) begin
            checks++; errors++;
            $display("FAIL resp_timeout: got no resp expected resp within 40 cycles (addr 0x%08h)", addr);
        end else begin
            @(negedge clk);
            check("resp_one_cycle", 32'(o_resp), 32'd0);
            check("rdata_idle_zero", o_rdata, 32'd0);
        end
    endtask

    // Reference for the offset instance: word array indexed by byte offset / 4
    task automatic model_b(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] mbe,
                           output logic [31:0] exp_rdata, output logic exp_err);
        longint off;
        int     w;
        off = longint'(addr) - longint'(B_BASE);
        exp_err = (off < 0) || (off >= 4 * longint'(B_DEPTH)) || (rd && wr);
        exp_rdata = '0;
        if (!exp_err) begin
            w = int'(off / 4);
            if (rd) begin
                exp_rdata = bmem[w];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (mbe[b]) bmem[w][8*b +: 8] = wdata[8*b +: 8];
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rdata, exp_rdata, addr, wdata;
        logic        err, exp_err, rd, wr;
        logic [3:0]  mbe;
        int          lat, nresp, j, r;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_a_resp", 32'(a_resp), 32'd0);
        check("reset_a_err", 32'(a_err), 32'd0);
        check("reset_a_rdata", a_rdata, 32'd0);
        check("reset_b_resp", 32'(b_resp), 32'd0);
        check("reset_b_rdata", b_rdata, 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Directed vectors on the LATENCY=2 instance
        vecs.push_back(mk(1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 4'b1111, 32'h0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 32'h100, 32'h0, 4'b1111, 32'hDEADBEEF, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 32'h200, 32'h11223344, 4'b1111, 32'h0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 32'h200, 32'h00AA0000, 4'b0100, 32'h0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 32'h200, 32'h0000BBCC, 4'b0011, 32'h0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 32'h200, 32'hFFFFFFFF, 4'b0000, 32'h11AABBCC, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 32'h0, 32'hCAFEF00D, 4'b1111, 32'h0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b1, 32'h0, 32'hFFFFFFFF, 4'b1111, 32'h0, 1'b1));
        vecs.push_back(mk(1'b1, 1'b0, 32'h0, 32'h0, 4'b1111, 32'hCAFEF00D, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, A_BASE + 4 * A_DEPTH, 32'h0, 4'b1111, 32'h0, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 32'hFFFF_FFFC, 32'h12345678, 4'b1111, 32'h0, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 32'h204, 32'hA5A5A5A5, 4'b1111, 32'h0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 32'h204, 32'h12345678, 4'b0000, 32'h0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 32'h204, 32'h0, 4'b0000, 32'hA5A5A5A5, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 32'h103, 32'h0, 4'b1111, 32'hDEADBEEF, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 32'hFFC, 32'h01020304, 4'b1111, 32'h0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 32'hFFC, 32'h0, 4'b1111, 32'h01020304, 1'b0));

        foreach (vecs[i]) begin
            access(1'b0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].mbe, 0,
                   rdata, err, lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(A_LAT));
            check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
        end

        // Request dropped one cycle after acceptance still commits
        access(1'b0, 1'b0, 1'b1, 32'h10, 32'h5, 4'b1111, 1, rdata, err, lat);
        check("drop_latency", 32'(lat), 32'(A_LAT));
        check("drop_err", 32'(err), 32'd0);
        access(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 4'b1111, 0, rdata, err, lat);
        check("drop_readback", rdata, 32'h5);

        // Reset asserted during BUSY aborts the write
        access(1'b0, 1'b0, 1'b1, 32'h20, 32'h77665544, 4'b1111, 0, rdata, err, lat);
        @(negedge clk);
        sel = 1'b0; t_write = 1'b1; t_addr = 32'h20; t_wdata = 32'hBAD0BAD0; t_mbe = 4'b1111;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_resp_immediate", 32'(a_resp), 32'd0);
        check("rst_rdata_immediate", a_rdata, 32'd0);
        @(negedge clk);
        t_write = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        nresp = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (a_resp) nresp++;
        end
        check("rst_no_resp_after", 32'(nresp), 32'd0);
        access(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 4'b1111, 0, rdata, err, lat);
        check("rst_word_unchanged", rdata, 32'h77665544);

        // Fill the offset instance so every word is known to the model
        for (int i = 0; i < int'(B_DEPTH); i++) begin
            addr = B_BASE + 32'(4 * i);
            wdata = $urandom;
            model_b(1'b0, 1'b1, addr, wdata, 4'b1111, exp_rdata, exp_err);
            access(1'b1, 1'b0, 1'b1, addr, wdata, 4'b1111, 0, rdata, err, lat);
            if (i == 0) check("fill_latency", 32'(lat), 32'(B_LAT));
        end

        // Back-to-back reads with the request held high, LATENCY=1
        @(negedge clk);
        sel = 1'b1; t_read = 1'b1; t_write = 1'b0; t_mbe = 4'b1111;
        j = 0;
        t_addr = B_BASE + 32'(4 * j);
        nresp = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("b2b_resp_cycle%0d", k), 32'(o_resp), 32'((k % 2) == 0));
            if (o_resp) begin
                nresp++;
                check($sformatf("b2b_rdata%0d", j), o_rdata, bmem[j]);
                j++;
                t_addr = B_BASE + 32'(4 * j);
            end
            if (k == 9) t_read = 1'b0;
        end
        @(negedge clk);
        if (o_resp) nresp++;
        check("b2b_resp_count", 32'(nresp), 32'd5);

        // Random traffic against the model on the offset instance
        for (int i = 0; i < 150; i++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) addr = B_BASE - 32'(4 * $urandom_range(1, 8));
            else if (r == 1) addr = B_BASE + 32'(4 * B_DEPTH) + 32'(4 * $urandom_range(0, 8));
            else addr = B_BASE + 32'(4 * $urandom_range(0, B_DEPTH - 1)) + 32'($urandom_range(0, 3));
            r = int'($urandom_range(0, 9));
            rd = (r < 5) || (r == 9);
            wr = (r >= 5);
            wdata = $urandom;
            mbe = 4'($urandom_range(0, 15));
            model_b(rd, wr, addr, wdata, mbe, exp_rdata, exp_err);
            access(1'b1, rd, wr, addr, wdata, mbe, 0, rdata, err, lat);
            check($sformatf("rnd%0d_latency", i), 32'(lat), 32'(B_LAT));
            check($sformatf("rnd%0d_err", i), 32'(err), 32'(exp_err));
            check($sformatf("rnd%0d_rdata", i), rdata, exp_rdata);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
